rd_ptr_empty_lvl: RTL and testbench

//  Read-domain pointer/empty stage of the asynchronous FIFO; counterpart of the write-pointer/full stage.

---
 rtl/rd_ptr_empty_lvl_if.sv | 27 ++
 rtl/rd_ptr_empty_lvl.sv | 80 ++++++++
 tb/tb_rd_ptr_empty_lvl.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/rd_ptr_empty_lvl_if.sv
// Read-side FIFO control bundle: consumer requests, unsynchronized write pointer,
// and the read pointer/status returned by the read-domain pointer stage.
interface rd_ptr_empty_lvl_if #(
    parameter int unsigned ADDR_W = 3
);
    logic              rd_en;
    logic              clr_uflow;
    logic [ADDR_W:0]   wrt_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W-1:0] rd_addr;
    logic              empty;
    logic              almost_empty;
    logic [ADDR_W:0]   rd_count;
    logic              underflow;

    // Consumer / environment side
    modport master (
        output rd_en, clr_uflow, wrt_ptr,
        input  rd_ptr, rd_addr, empty, almost_empty, rd_count, underflow
    );

    // Read pointer stage side
    modport slave (
        input  rd_en, clr_uflow, wrt_ptr,
        output rd_ptr, rd_addr, empty, almost_empty, rd_count, underflow
    );
endinterface

// File: rtl/rd_ptr_empty_lvl.sv
// Read-domain pointer/empty stage of an async FIFO: syncs the write Gray pointer,
// advances the binary+Gray read pointer and registers empty, level and underflow.
module rd_ptr_empty_lvl #(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    rd_ptr_empty_lvl_if.slave bus
);
    localparam int unsigned PW = ADDR_W + 1;

    logic [PW-1:0] rd_bin;
    logic [PW-1:0] rd_gray;
    logic [PW-1:0] rq1;
    logic [PW-1:0] rq2;
    logic          empty_q;
    logic          almost_empty_q;
    logic [PW-1:0] count_q;
    logic          underflow_q;

    logic          read_ok_c;
    logic [PW-1:0] rd_bin_next_c;
    logic [PW-1:0] rd_gray_next_c;
    logic [PW-1:0] wbin_c;
    logic [PW-1:0] level_next_c;

    // Next pointer, synchronized write position and resulting fill level
    always_comb begin
        read_ok_c      = bus.rd_en & ~empty_q;
        rd_bin_next_c  = rd_bin + PW'(read_ok_c);
        rd_gray_next_c = (rd_bin_next_c >> 1) ^ rd_bin_next_c;
        wbin_c         = '0;
        for (int i = 0; i < int'(PW); i++) begin
            wbin_c[i] = ^(rq2 >> i);
        end
        level_next_c   = wbin_c - rd_bin_next_c;
    end

    // Two-flop synchronizer for the write-domain Gray pointer
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rq1 <= '0;
            rq2 <= '0;
        end else begin
            rq1 <= bus.wrt_ptr;
            rq2 <= rq1;
        end
    end

    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            rd_bin         <= '0;
            rd_gray        <= '0;
            empty_q        <= 1'b1;
            almost_empty_q <= 1'b1;
            count_q        <= '0;
            underflow_q    <= 1'b0;
        end else begin
            rd_bin         <= rd_bin_next_c;
            rd_gray        <= rd_gray_next_c;
            empty_q        <= (rd_gray_next_c == rq2);
            almost_empty_q <= (level_next_c <= PW'(AE_LEVEL));
            count_q        <= level_next_c;
            // A rejected read outranks a same-cycle clear
            if (bus.rd_en && empty_q) begin
                underflow_q <= 1'b1;
            end else if (bus.clr_uflow) begin
                underflow_q <= 1'b0;
            end
        end
    end

    assign bus.rd_ptr       = rd_gray;
    assign bus.rd_addr      = rd_bin[ADDR_W-1:0];
    assign bus.empty        = empty_q;
    assign bus.almost_empty = almost_empty_q;
    assign bus.rd_count     = count_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_rd_ptr_empty_lvl.sv
// Bench for rd_ptr_empty_lvl: directed scenarios plus random traffic, checked against
// an integer write/read-count model of the read-side FIFO behaviour.
module tb_rd_ptr_empty_lvl;
    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned AE_LEVEL = 2;

    logic rd_clk;
    logic rd_rst;
    bit   clk_run;

    rd_ptr_empty_lvl_if #(.ADDR_W(ADDR_W)) bus ();

    rd_ptr_empty_lvl #(.ADDR_W(ADDR_W), .AE_LEVEL(AE_LEVEL)) dut (
        .rd_clk (rd_clk),
        .rd_rst (rd_rst),
        .bus    (bus)
    );

    int total;
    int bad;

    // Model: total words written/read as plain integers, write count seen through two edges of delay
    int w_cnt;
    int m_rd;
    int m_h1;
    int m_h2;
    int m_level;
    bit m_empty;
    bit m_uflow;

    function automatic logic [3:0] to_gray(input int n);
        logic [3:0] b;
        b = 4'(n % 16);
        return b ^ (b >> 1);
    endfunction

    always_comb bus.wrt_ptr = to_gray(w_cnt);

    initial begin
        forever begin
            #5;
            if (clk_run) rd_clk = ~rd_clk;
        end
    end

    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            m_rd    <= 0;
            m_h1    <= 0;
            m_h2    <= 0;
            m_level <= 0;
            m_empty <= 1'b1;
            m_uflow <= 1'b0;
        end else begin
            m_uflow <= (bus.rd_en && m_empty) ? 1'b1 : (bus.clr_uflow ? 1'b0 : m_uflow);
            m_rd    <= m_rd + int'(bus.rd_en && !m_empty);
            m_level <= m_h2 - (m_rd + int'(bus.rd_en && !m_empty));
            m_empty <= ((m_h2 - (m_rd + int'(bus.rd_en && !m_empty))) == 0);
            m_h2    <= m_h1;
            m_h1    <= w_cnt;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        check("empty",        int'(bus.empty),        int'(m_empty));
        check("almost_empty", int'(bus.almost_empty), int'(m_level <= int'(AE_LEVEL)));
        check("rd_count",     int'(bus.rd_count),     m_level);
        check("rd_ptr",       int'(bus.rd_ptr),       int'(to_gray(m_rd)));
        check("rd_addr",      int'(bus.rd_addr),      m_rd % 8);
        check("underflow",    int'(bus.underflow),    int'(m_uflow));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_empty"},  int'(bus.empty),        1);
        check({tag, "_ae"},     int'(bus.almost_empty), 1);
        check({tag, "_count"},  int'(bus.rd_count),     0);
        check({tag, "_ptr"},    int'(bus.rd_ptr),       0);
        check({tag, "_addr"},   int'(bus.rd_addr),      0);
        check({tag, "_uflow"},  int'(bus.underflow),    0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge rd_clk);
            #1;
            check_model();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] prev_ptr;
        bit saw_wrap;
        int writes;

        total         = 0;
        bad           = 0;
        rd_clk        = 1'b0;
        clk_run       = 1'b0;
        rd_rst        = 1'b0;
        bus.rd_en     = 1'b0;
        bus.clr_uflow = 1'b0;
        w_cnt         = 0;

        // Reset with the clock stopped
        #1 rd_rst = 1'b1;
        #2 check_reset_vals("rst_noclk");
        clk_run = 1'b1;
        @(posedge rd_clk);
        #1 rd_rst = 1'b0;
        tick(1);

        // Single word: visible on the third edge, then read it back
        w_cnt = 1;
        tick(2);
        check("single_still_empty", int'(bus.empty), 1);
        tick(1);
        check("single_not_empty", int'(bus.empty), 0);
        check("single_count", int'(bus.rd_count), 1);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        check("single_ptr", int'(bus.rd_ptr), 1);
        check("single_addr", int'(bus.rd_addr), 1);
        check("single_empty_after", int'(bus.empty), 1);
        check("single_count_after", int'(bus.rd_count), 0);

        // Fill to full, then read down to the almost-empty threshold
        w_cnt = m_rd + 8;
        tick(3);
        check("full_count", int'(bus.rd_count), 8);
        check("full_ae", int'(bus.almost_empty), 0);
        bus.rd_en = 1'b1;
        tick(6);
        bus.rd_en = 1'b0;
        check("ae_count", int'(bus.rd_count), 2);
        check("ae_flag", int'(bus.almost_empty), 1);
        check("ae_not_empty", int'(bus.empty), 0);
        bus.rd_en = 1'b1;
        tick(2);
        bus.rd_en = 1'b0;
        check("drained_empty", int'(bus.empty), 1);

        // Underflow: rejected read, sticky, clear, and set-beats-clear
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        check("uflow_ptr_hold", int'(bus.rd_ptr), 13);
        check("uflow_set", int'(bus.underflow), 1);
        tick(3);
        check("uflow_sticky", int'(bus.underflow), 1);
        bus.clr_uflow = 1'b1;
        tick(1);
        bus.clr_uflow = 1'b0;
        check("uflow_clr", int'(bus.underflow), 0);
        bus.rd_en     = 1'b1;
        bus.clr_uflow = 1'b1;
        tick(1);
        bus.rd_en     = 1'b0;
        check("uflow_set_wins", int'(bus.underflow), 1);
        tick(1);
        bus.clr_uflow = 1'b0;
        check("uflow_clr2", int'(bus.underflow), 0);

        // Wrap: 20 Gray-stepped writes, consumer reads whenever data is available
        saw_wrap = 1'b0;
        writes   = 0;
        for (int c = 0; c < 60; c++) begin
            if (writes < 20 && (w_cnt - m_rd) < 8) begin
                w_cnt++;
                writes++;
            end
            bus.rd_en = !m_empty;
            prev_ptr  = bus.rd_ptr;
            tick(1);
            if (prev_ptr == 4'b1000 && bus.rd_ptr == 4'b0000) saw_wrap = 1'b1;
        end
        bus.rd_en = 1'b0;
        check("wrap_seen", int'(saw_wrap), 1);
        check("wrap_no_uflow", int'(bus.underflow), 0);
        check("wrap_drained", int'(bus.empty), 1);

        // Random traffic including underflows and clears
        for (int c = 0; c < 400; c++) begin
            bus.rd_en     = ($urandom_range(0, 3) != 0);
            bus.clr_uflow = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 1) == 1 && (w_cnt - m_rd) < 8) w_cnt++;
            tick(1);
        end
        bus.rd_en     = 1'b0;
        bus.clr_uflow = 1'b0;

        // Mid-operation reset between edges
        w_cnt = m_rd + 5;
        tick(3);
        check("midrst_pre_count", int'(bus.rd_count), 5);
        w_cnt  = 0;
        rd_rst = 1'b1;
        #1 check_reset_vals("rst_midop");
        tick(2);
        rd_rst = 1'b0;
        tick(4);
        check("post_rst_empty", int'(bus.empty), 1);
        check("post_rst_count", int'(bus.rd_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
